// File: rtl/saida_display.sv
// rtl/saida_display.sv - captures the core's OUT value, converts it to BCD by
// double-dabble and drives active-low seven-segment digits with blanking/overflow.
module saida_display #(
  parameter int DATA_WIDTH  = 28,
  parameter int NUM_DIGITS  = 8,
  parameter int BLANK_ZEROS = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   display,
  input  logic                    OpOut,
  output logic [7*NUM_DIGITS-1:0] segmentos,
  output logic                    busy,
  output logic                    overflow
);

  localparam int BCD_DIGITS = NUM_DIGITS + 2;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = $clog2(DATA_WIDTH + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   bin;
  logic [BCD_W-1:0]        bcd;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_WIDTH-1:0]   pend_val;
  logic                    pend_full;

  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W-1:0]        bcd_shift;
  logic [DATA_WIDTH-1:0]   bin_shift;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic                    ovf_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // One double-dabble step: correct nibbles >=5, then shift {bcd,bin} left.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], bin[DATA_WIDTH-1]};
    bin_shift = {bin[DATA_WIDTH-2:0], 1'b0};
  end

  // Digit encoding from the finished BCD; scanned top-down to track leading zeros.
  always_comb begin
    logic       lead;
    logic [3:0] d;
    seg_next = '0;
    lead     = 1'b1;
    d        = 4'd0;
    ovf_next = |bcd[BCD_W-1:4*NUM_DIGITS];
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      d = bcd[4*k +: 4];
      if (d != 4'd0)
        lead = 1'b0;
      if (ovf_next)
        seg_next[7*k +: 7] = SEG_DASH;
      else if ((BLANK_ZEROS != 0) && lead && (k != 0))
        seg_next[7*k +: 7] = SEG_BLANK;
      else
        seg_next[7*k +: 7] = seg7(d);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      pend_val  <= '0;
      pend_full <= 1'b0;
      segmentos <= {NUM_DIGITS{SEG_BLANK}};
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (OpOut) begin
            bin   <= display;
            bcd   <= '0;
            cnt   <= CNT_W'(DATA_WIDTH);
            busy  <= 1'b1;
            state <= CONV;
          end
        end

        CONV: begin
          if (OpOut) begin
            pend_val  <= display;
            pend_full <= 1'b1;
          end
          bcd <= bcd_shift;
          bin <= bin_shift;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= LOAD;
        end

        LOAD: begin
          segmentos <= seg_next;
          overflow  <= ovf_next;
          // A value arriving on this edge is newer than anything pending.
          if (OpOut) begin
            bin       <= display;
            bcd       <= '0;
            cnt       <= CNT_W'(DATA_WIDTH);
            pend_full <= 1'b0;
            state     <= CONV;
          end else if (pend_full) begin
            bin       <= pend_val;
            bcd       <= '0;
            cnt       <= CNT_W'(DATA_WIDTH);
            pend_full <= 1'b0;
            state     <= CONV;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
